// File: rtl/dense_controller_if.sv
// dense_controller_if: Avalon-MM bus bundle, used for both the CPU-facing slave port and the SDRAM-facing master port.
interface dense_controller_if #(parameter int AW = 32);
    logic          waitrequest;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [31:0]   readdata;
    logic [31:0]   writedata;
    modport master(input waitrequest, readdata, output address, read, write, writedata);
    modport slave(output waitrequest, readdata, input address, read, write, writedata);
endinterface

// File: rtl/dense_controller.sv
// dense_controller: computes y = ReLU(W*x + b) on Q8.24 words in SDRAM, configured over an Avalon-MM slave port.
module dense_controller (
    input  logic               clk,
    input  logic               reset,
    dense_controller_if.slave  slv,
    dense_controller_if.master mst
);
    typedef enum logic [2:0] {IDLE, RD_BIAS, RD_W, RD_X, MAC, WR_OUT} state_t;
    state_t state, state_nx;
    logic [31:0] b_base, w_base, x_base, o_base, n, i, j, w_ptr, acc;
    logic signed [31:0] wt, act;
    logic signed [63:0] prod;
    logic busy, cfg_we, start, last_j, last_i, acc_ok, unused;

    assign busy = state != IDLE;
    assign cfg_we = slv.write && !busy;
    assign start = cfg_we && slv.address == 3'd0 && n != 32'd0;
    assign last_j = j == n - 32'd1;
    assign last_i = i == n - 32'd1;
    assign acc_ok = !mst.waitrequest;
    assign prod = 64'(wt) * 64'(act);
    assign unused = ^{prod[63:56], prod[23:0]};
    assign slv.waitrequest = busy && (slv.read || slv.write);

    always_comb
        case (slv.address)
            3'd0:    slv.readdata = {31'b0, busy};
            3'd1:    slv.readdata = b_base;
            3'd2:    slv.readdata = w_base;
            3'd3:    slv.readdata = x_base;
            3'd4:    slv.readdata = o_base;
            3'd5:    slv.readdata = n;
            default: slv.readdata = '0;
        endcase

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        mst.read = state == RD_BIAS || state == RD_W || state == RD_X;
        mst.write = state == WR_OUT;
        mst.writedata = (state == WR_OUT && !acc[31]) ? acc : 32'd0;
        mst.address = state == RD_BIAS ? b_base + i :
                      state == RD_W    ? w_ptr :
                      state == RD_X    ? x_base + j :
                      state == WR_OUT  ? o_base + i : 32'd0;
        case (state)
            IDLE:    state_nx = start ? RD_BIAS : IDLE;
            RD_BIAS: state_nx = acc_ok ? RD_W : RD_BIAS;
            RD_W:    state_nx = acc_ok ? RD_X : RD_W;
            RD_X:    state_nx = acc_ok ? MAC : RD_X;
            MAC:     state_nx = last_j ? WR_OUT : RD_W;
            WR_OUT:  state_nx = !acc_ok ? WR_OUT : last_i ? IDLE : RD_BIAS;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            b_base <= '0;
            w_base <= '0;
            x_base <= '0;
            o_base <= '0;
            n <= '0;
            i <= '0;
            j <= '0;
            w_ptr <= '0;
            acc <= '0;
            wt <= '0;
            act <= '0;
        end else begin
            if (cfg_we && slv.address == 3'd1) b_base <= slv.writedata;
            if (cfg_we && slv.address == 3'd2) w_base <= slv.writedata;
            if (cfg_we && slv.address == 3'd3) x_base <= slv.writedata;
            if (cfg_we && slv.address == 3'd4) o_base <= slv.writedata;
            if (cfg_we && slv.address == 3'd5) n <= slv.writedata;
            if (start) begin
                i <= '0;
                w_ptr <= w_base;
            end
            if (state == RD_BIAS && acc_ok) begin
                acc <= mst.readdata;
                j <= '0;
            end
            // Weights are row-major and visited in order, so one running pointer covers W+i*N+j.
            if (state == RD_W && acc_ok) begin
                wt <= mst.readdata;
                w_ptr <= w_ptr + 32'd1;
            end
            if (state == RD_X && acc_ok) act <= mst.readdata;
            if (state == MAC) begin
                acc <= acc + prod[55:24];
                if (!last_j) j <= j + 32'd1;
            end
            if (state == WR_OUT && acc_ok) i <= i + 32'd1;
        end
endmodule

// File: tb/tb_dense_controller.sv
// tb_dense_controller: randomized SDRAM-backed bench with a queue scoreboard fed by an arithmetic reference model.
module tb_dense_controller;
    logic clk = 0;
    logic reset = 1;
    dense_controller_if #(.AW(3)) sbus();
    dense_controller_if mbus();
    dense_controller dut (.clk(clk), .reset(reset), .slv(sbus), .mst(mbus));

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [31:0] data;} exp_t;
    exp_t sb[$];
    logic [31:0] mem [0:255];
    int tests = 0;
    int fails = 0;
    int n_wr = 0;
    int n_rd = 0;
    bit stall_en = 0;

    assign mbus.readdata = mem[mbus.address[7:0]];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        mbus.waitrequest = 0;
        forever begin
            @(posedge clk);
            #1 mbus.waitrequest = stall_en && ($urandom_range(0, 2) != 0);
        end
    end

    // SDRAM model and scoreboard monitor; sampled mid-cycle, the values seen here are those the next edge accepts.
    initial begin
        logic [31:0] p_addr, p_wd;
        logic p_rd, p_wr, p_wait;
        exp_t e;
        p_rd = 0; p_wr = 0; p_wait = 0; p_addr = 0; p_wd = 0;
        forever begin
            @(negedge clk);
            if ((p_rd || p_wr) && p_wait) begin
                check("hold_strobe", {30'b0, mbus.read, mbus.write}, {30'b0, p_rd, p_wr});
                check("hold_addr", mbus.address, p_addr);
                if (p_wr) check("hold_wdata", mbus.writedata, p_wd);
            end
            if (mbus.read && mbus.write) check("one_strobe", 32'd1, 32'd0);
            if ((mbus.read || mbus.write) && mbus.address[31:8] != 0) check("addr_range", mbus.address, 32'd0);
            if (!mbus.waitrequest && mbus.read) n_rd++;
            if (!mbus.waitrequest && mbus.write) begin
                n_wr++;
                mem[mbus.address[7:0]] = mbus.writedata;
                if (sb.size() == 0) check("unexpected_write", mbus.address, 32'hFFFF_FFFF);
                else begin
                    e = sb.pop_front();
                    check("wr_addr", mbus.address, e.addr);
                    check("wr_data", mbus.writedata, e.data);
                end
            end
            p_rd = mbus.read; p_wr = mbus.write; p_wait = mbus.waitrequest;
            p_addr = mbus.address; p_wd = mbus.writedata;
        end
    end

    task automatic expect_run(int b, int w, int x, int o, int n);
        for (int i = 0; i < n; i++) begin
            logic signed [31:0] acc;
            acc = mem[b + i];
            for (int j = 0; j < n; j++) begin
                longint p;
                p = longint'($signed(mem[w + i * n + j])) * longint'($signed(mem[x + j]));
                acc += 32'(p >>> 24);
            end
            sb.push_back('{addr: 32'(o + i), data: acc[31] ? 32'd0 : 32'(acc)});
        end
    endtask

    task automatic reg_write(logic [2:0] a, logic [31:0] d);
        @(negedge clk);
        sbus.address = a; sbus.writedata = d; sbus.write = 1;
        #1 check("slave_wait_idle", {31'b0, sbus.waitrequest}, 32'd0);
        @(negedge clk);
        sbus.write = 0;
    endtask

    task automatic reg_read(logic [2:0] a, output logic [31:0] d);
        sbus.address = a; sbus.read = 1;
        #1 d = sbus.readdata;
        sbus.read = 0;
    endtask

    task automatic cfg(int b, int w, int x, int o);
        reg_write(1, 32'(b)); reg_write(2, 32'(w)); reg_write(3, 32'(x)); reg_write(4, 32'(o));
    endtask

    task automatic wait_idle(int budget);
        logic [31:0] d;
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            reg_read(0, d);
            if (d == 0) break;
        end
        check("run_timeout", 32'(k == budget), 32'd0);
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic init_s1();
        for (int i = 0; i < 9; i++) mem[1 + i] = 32'(i + 1) << 24;
        mem[10] = 32'h0080_0000; mem[11] = 32'h0040_0000; mem[12] = 32'h0020_0000;
        mem[15] = 32'hFF00_0000; mem[16] = 32'h0200_0000; mem[17] = 32'hFD00_0000;
        for (int i = 32; i < 35; i++) mem[i] = 32'hDEAD_BEEF;
    endtask

    task automatic check_s1();
        check("s1_mem32", mem[32], 32'h0060_0000);
        check("s1_mem33", mem[33], 32'h0600_0000);
        check("s1_mem34", mem[34], 32'h03A0_0000);
    endtask

    initial begin
        logic [31:0] d;
        int w0, r0, n;
        sbus.address = 0; sbus.read = 0; sbus.write = 0; sbus.writedata = 0;
        for (int i = 0; i < 256; i++) mem[i] = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        for (int a = 0; a < 8; a++) begin
            reg_read(3'(a), d);
            check("reset_reg", d, 32'd0);
        end
        check("reset_strobes", {30'b0, mbus.read, mbus.write}, 32'd0);
        check("reset_addr", mbus.address, 32'd0);
        check("reset_wdata", mbus.writedata, 32'd0);

        init_s1();
        cfg(15, 1, 10, 32);
        reg_write(5, 3);
        expect_run(15, 1, 10, 32, 3);
        reg_write(0, 0);
        wait_idle(500);
        check_s1();

        for (int i = 0; i < 9; i++) mem[100 + i] = (i % 2 == 0) ? 32'h0080_0000 : 32'h0100_0000;
        mem[15] = 32'hF700_0000; mem[16] = 32'h0100_0000; mem[17] = 32'h0;
        cfg(15, 100, 32, 200);
        expect_run(15, 100, 32, 200, 3);
        reg_write(0, 0);
        wait_idle(500);
        check("s2_mem200", mem[200], 32'h0);
        check("s2_mem201", mem[201], 32'h0800_0000);
        check("s2_mem202", mem[202], 32'h0800_0000);

        init_s1();
        cfg(15, 1, 10, 32);
        stall_en = 1;
        expect_run(15, 1, 10, 32, 3);
        reg_write(0, 0);
        wait_idle(2000);
        stall_en = 0;
        check_s1();

        init_s1();
        expect_run(15, 1, 10, 32, 3);
        reg_write(0, 0);
        w0 = n_wr + 3;
        @(negedge clk);
        sbus.address = 2; sbus.writedata = 555; sbus.write = 1;
        repeat (4) begin
            @(negedge clk);
            #1 check("busy_cfg_wait", {31'b0, sbus.waitrequest}, 32'd1);
        end
        sbus.write = 0;
        sbus.address = 0; sbus.write = 1;
        repeat (3) begin
            @(negedge clk);
            #1 check("busy_start_wait", {31'b0, sbus.waitrequest}, 32'd1);
            check("reg0_mid", sbus.readdata, 32'd1);
        end
        sbus.write = 0;
        wait_idle(500);
        repeat (10) @(negedge clk);
        reg_read(2, d);
        check("reg2_kept", d, 32'd1);
        reg_read(0, d);
        check("reg0_after", d, 32'd0);
        check("no_second_run", 32'(n_wr), 32'(w0));
        check_s1();

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 20; i < 64; i++) mem[i] = $urandom;
            stall_en = $urandom_range(0, 1);
            cfg(20, 40, 60, 70);
            reg_write(5, 32'(n));
            expect_run(20, 40, 60, 70, n);
            reg_write(0, 0);
            wait_idle(3000);
            stall_en = 0;
        end

        init_s1();
        cfg(15, 1, 10, 32);
        reg_write(5, 3);
        expect_run(15, 1, 10, 32, 3);
        reg_write(0, 0);
        repeat (20) @(posedge clk);
        #2 reset = 1;
        #1 check("rst_strobes", {30'b0, mbus.read, mbus.write}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            reg_read(3'(a), d);
            check("rst_reg", d, 32'd0);
        end
        sb.delete();
        w0 = n_wr;
        @(negedge clk);
        reset = 0;
        repeat (50) @(negedge clk);
        check("rst_no_writes", 32'(n_wr), 32'(w0));

        w0 = n_wr; r0 = n_rd;
        reg_write(0, 0);
        repeat (20) @(negedge clk);
        reg_read(0, d);
        check("n0_busy", d, 32'd0);
        check("n0_reads", 32'(n_rd), 32'(r0));
        check("n0_writes", 32'(n_wr), 32'(w0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
